// File: rtl/window_motor_ctrl.sv
// Window motor sequencer: soft-start ramp, braking dead time, optional pinch reversal.
// Define ANTI_PINCH_EN to build pinch detection with REV_DEAD, REVERSE and LOCK.
module window_motor_ctrl #(
    parameter int unsigned T_PERIOD   = 10000,
    parameter int unsigned DUTY_W     = 14,
    parameter int unsigned RAMP_STEP  = 500,
    parameter int unsigned RAMP_TICK  = 100000,
    parameter int unsigned BLANK_TIME = 5000000,
    parameter int unsigned DEAD_TIME  = 200000,
    parameter int unsigned REV_TIME   = 30000000
) (
    input  logic              SYSCLK,
    input  logic              RST_N,
    input  logic              UP_REQ,
    input  logic              DOWN_REQ,
    input  logic              PINCH,
    input  logic              TOP_LIM,
    input  logic              BOT_LIM,
    output logic [DUTY_W-1:0] DUTY,
    output logic              DIR,
    output logic              BUSY,
    output logic              PINCH_EVT,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RAMP     = 3'd1,
        S_RUN      = 3'd2,
        S_STOP     = 3'd3,
        S_REV_DEAD = 3'd4,
        S_REVERSE  = 3'd5,
        S_LOCK     = 3'd6,
        S_BAD      = 3'd7
    } state_e;

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(T_PERIOD);
    localparam logic [DUTY_W-1:0] DUTY_HALF = DUTY_W'(T_PERIOD / 2);
    localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'((RAMP_STEP < T_PERIOD) ? RAMP_STEP : T_PERIOD);

    logic [4:0]        sync1_q, sync2_q;
    logic              up_s, down_s, top_s, bot_s, pinch_s;
    state_e            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d, busy_q, busy_d, pinch_evt_q, pinch_evt_d;
    logic              pinch_acc, ramp_tick, lim_hit, req_drop;
    logic [32:0]       timer_cnt;
    logic              dead_done, tick_done, rev_done, lock_done, ramp_full;

    assign {pinch_s, bot_s, top_s, down_s, up_s} = sync2_q;

    // timer_cnt is the number of cycles spent in the state once this cycle ends.
    assign timer_cnt = {1'b0, timer_q} + 33'd1;
    assign dead_done = timer_cnt >= 33'(DEAD_TIME);
    assign tick_done = timer_cnt >= 33'(RAMP_TICK);
    assign rev_done  = timer_cnt >= 33'(REV_TIME);
    assign lock_done = timer_q >= DEAD_TIME;
    assign ramp_full = (33'(duty_q) + 33'(RAMP_STEP)) >= 33'(T_PERIOD);
    assign lim_hit   = dir_q ? top_s : bot_s;
    assign req_drop  = dir_q ? (!up_s || down_s) : (!down_s || up_s);

`ifdef ANTI_PINCH_EN
    logic [31:0] blank_q, blank_d;
    logic        pinch_ok;

    assign blank_d  = (state_q == S_IDLE) ? '0 : ((blank_q != '1) ? blank_q + 32'd1 : blank_q);
    assign pinch_ok = pinch_s && dir_q && (blank_q >= BLANK_TIME);

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) blank_q <= '0;
        else        blank_q <= blank_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = pinch_s ^ (BLANK_TIME != 0) ^ (REV_TIME != 0);
`endif

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            pinch_evt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every flop samples pre-edge values.
            sync1_q     <= {PINCH, BOT_LIM, TOP_LIM, DOWN_REQ, UP_REQ};
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            pinch_evt_q <= pinch_evt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d   = state_q;
        pinch_acc = 1'b0;
        ramp_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((up_s && !down_s && !top_s) || (down_s && !up_s && !bot_s)) state_d = S_RAMP;
            end
            S_RAMP, S_RUN: begin
                if (lim_hit) begin
                    state_d = S_STOP;
`ifdef ANTI_PINCH_EN
                end else if (pinch_ok) begin
                    pinch_acc = 1'b1;
                    state_d   = S_REV_DEAD;
`endif
                end else if (req_drop) begin
                    state_d = S_STOP;
                end else if (state_q == S_RAMP && tick_done) begin
                    ramp_tick = 1'b1;
                    if (ramp_full) state_d = S_RUN;
                end
            end
            S_STOP: if (dead_done) state_d = S_IDLE;
`ifdef ANTI_PINCH_EN
            S_REV_DEAD: if (dead_done) state_d = S_REVERSE;
            S_REVERSE:  if (rev_done || bot_s) state_d = S_LOCK;
            // Dead time counts only once both buttons are released.
            S_LOCK:     if (!up_s && !down_s && lock_done) state_d = S_IDLE;
`endif
            default: state_d = S_STOP;
        endcase

        if (state_d != state_q || ramp_tick)             timer_d = '0;
        else if (state_q == S_LOCK && (up_s || down_s)) timer_d = '0;
        else if (timer_q != '1)                         timer_d = timer_q + 32'd1;
        else                                            timer_d = timer_q;
    end

    always_comb begin
        duty_d      = '0;
        dir_d       = dir_q;
        busy_d      = (state_d != S_IDLE);
        pinch_evt_d = pinch_acc;
        case (state_d)
            S_RAMP: begin
                if (state_q == S_IDLE) duty_d = DUTY_STEP;
                else if (ramp_tick)    duty_d = duty_q + DUTY_STEP;
                else                   duty_d = duty_q;
            end
            S_RUN:     duty_d = DUTY_FULL;
            S_REVERSE: duty_d = DUTY_HALF;
            default:   duty_d = '0;
        endcase
        if (state_q == S_IDLE && state_d == S_RAMP) dir_d = up_s;
        if (state_d == S_REVERSE)                   dir_d = 1'b0;
    end

    assign DUTY      = duty_q;
    assign DIR       = dir_q;
    assign BUSY      = busy_q;
    assign PINCH_EVT = pinch_evt_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_window_motor_ctrl.sv
// Bench for window_motor_ctrl: arithmetic reference model checked every cycle plus directed literals.
module tb_window_motor_ctrl;

    localparam int TP = 100, STEP = 25, TICK = 10, BLANK = 50, DEAD = 4, REV = 200;
`ifdef ANTI_PINCH_EN
    localparam bit PINCH_BUILD = 1'b1;
`else
    localparam bit PINCH_BUILD = 1'b0;
`endif

    logic       SYSCLK, RST_N, UP_REQ, DOWN_REQ, PINCH, TOP_LIM, BOT_LIM;
    logic [7:0] DUTY;
    logic       DIR, BUSY, PINCH_EVT;
    logic [2:0] STATE;

    window_motor_ctrl #(
        .T_PERIOD(TP), .DUTY_W(8), .RAMP_STEP(STEP), .RAMP_TICK(TICK),
        .BLANK_TIME(BLANK), .DEAD_TIME(DEAD), .REV_TIME(REV)
    ) dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N), .UP_REQ(UP_REQ), .DOWN_REQ(DOWN_REQ),
        .PINCH(PINCH), .TOP_LIM(TOP_LIM), .BOT_LIM(BOT_LIM),
        .DUTY(DUTY), .DIR(DIR), .BUSY(BUSY), .PINCH_EVT(PINCH_EVT), .STATE(STATE)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number, edge of phase entry, and elapsed-time arithmetic.
    int         cyc, m_state, m_entry, m_blank0, m_rel;
    bit         m_dir, m_pevt;
    logic [4:0] m_s1, m_s2;

    always @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc = 0; m_state = 0; m_entry = 0; m_blank0 = 0; m_rel = 0;
            m_dir = 1'b0; m_pevt = 1'b0; m_s1 = '0; m_s2 = '0;
        end else begin
            logic [4:0] s;
            bit up, dn, top, bot, pin, lim, drop;
            int nxt, el;
            cyc++;
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = {PINCH, BOT_LIM, TOP_LIM, DOWN_REQ, UP_REQ};
            {pin, bot, top, dn, up} = s;
            nxt    = m_state;
            m_pevt = 1'b0;
            el     = cyc - m_entry;
            case (m_state)
                0: begin
                    if (up && !dn && !top) begin nxt = 1; m_dir = 1'b1; m_blank0 = cyc; end
                    else if (dn && !up && !bot) begin nxt = 1; m_dir = 1'b0; m_blank0 = cyc; end
                end
                1, 2: begin
                    lim  = m_dir ? top : bot;
                    drop = m_dir ? (!up || dn) : (!dn || up);
                    if (lim) nxt = 3;
                    else if (PINCH_BUILD && pin && m_dir && (cyc - m_blank0 - 1) >= BLANK) begin
                        nxt = 4; m_pevt = 1'b1;
                    end
                    else if (drop) nxt = 3;
                    else if (m_state == 1 && STEP * (1 + el / TICK) >= TP) nxt = 2;
                end
                3: if (el >= DEAD) nxt = 0;
                4: if (el >= DEAD) begin nxt = 5; m_dir = 1'b0; end
                5: if (el >= REV || bot) nxt = 6;
                6: begin
                    if (!up && !dn) begin
                        if (m_rel >= DEAD) nxt = 0;
                        else m_rel++;
                    end else m_rel = 0;
                end
                default: nxt = 3;
            endcase
            if (nxt != m_state) begin m_entry = cyc; m_rel = 0; end
            m_state = nxt;
        end
    end

    function automatic int exp_duty();
        int d;
        case (m_state)
            1: begin
                d = STEP * (1 + (cyc - m_entry) / TICK);
                if (d > TP) d = TP;
            end
            2:       d = TP;
            5:       d = TP / 2;
            default: d = 0;
        endcase
        return d;
    endfunction

    always @(negedge SYSCLK) begin
        if (RST_N === 1'b1) begin
            check("mdl_state", 32'(STATE), 32'(m_state));
            check("mdl_duty", 32'(DUTY), 32'(exp_duty()));
            check("mdl_dir", 32'(DIR), 32'(m_dir));
            check("mdl_busy", 32'(BUSY), 32'(m_state != 0));
            check("mdl_pinch_evt", 32'(PINCH_EVT), 32'(m_pevt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; UP_REQ = 1'b0; DOWN_REQ = 1'b0; PINCH = 1'b0; TOP_LIM = 1'b0; BOT_LIM = 1'b0;
        #12;
        check("rst_state", 32'(STATE), 0);
        check("rst_duty", 32'(DUTY), 0);
        check("rst_dir", 32'(DIR), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_pinch_evt", 32'(PINCH_EVT), 0);
        @(negedge SYSCLK);
        RST_N = 1'b1;
        step(2);

        // Close: ramp 25/50/75 then RUN at 100; release -> STOP for 4 cycles -> IDLE.
        UP_REQ = 1'b1;
        step(3);
        check("ramp_entry_state", 32'(STATE), 1);
        check("ramp_entry_duty", 32'(DUTY), 25);
        check("ramp_entry_dir", 32'(DIR), 1);
        check("ramp_entry_busy", 32'(BUSY), 1);
        step(10); check("ramp_duty_50", 32'(DUTY), 50);
        step(10); check("ramp_duty_75", 32'(DUTY), 75);
        check("ramp_still_state", 32'(STATE), 1);
        step(10); check("run_state", 32'(STATE), 2);
        check("run_duty", 32'(DUTY), 100);
        step(5);
        UP_REQ = 1'b0;
        step(3); check("stop_state", 32'(STATE), 3);
        check("stop_duty", 32'(DUTY), 0);
        step(3); check("stop_hold", 32'(STATE), 3);
        step(1); check("stop_to_idle", 32'(STATE), 0);
        check("idle_busy", 32'(BUSY), 0);

        // Pinch inside blanking is ignored; pinch after blanking reverses (pinch build).
        step(2);
        UP_REQ = 1'b1;
        step(3);
        step(30);
        PINCH = 1'b1; step(1); PINCH = 1'b0;
        step(2);
        check("blank_pinch_state", 32'(STATE), 2);
        check("blank_pinch_evt", 32'(PINCH_EVT), 0);
        step(47);
        PINCH = 1'b1; step(1); PINCH = 1'b0;
        step(2);
`ifdef ANTI_PINCH_EN
        check("pinch_evt", 32'(PINCH_EVT), 1);
        check("rev_dead_state", 32'(STATE), 4);
        check("rev_dead_duty", 32'(DUTY), 0);
        step(1); check("pinch_evt_single", 32'(PINCH_EVT), 0);
        step(3); check("reverse_state", 32'(STATE), 5);
        check("reverse_dir", 32'(DIR), 0);
        check("reverse_duty", 32'(DUTY), 50);
        step(199); check("reverse_hold", 32'(STATE), 5);
        step(1); check("lock_state", 32'(STATE), 6);
        check("lock_duty", 32'(DUTY), 0);
        step(10); check("lock_held_button", 32'(STATE), 6);
        UP_REQ = 1'b0;
        step(6); check("lock_dead", 32'(STATE), 6);
        step(1); check("lock_to_idle", 32'(STATE), 0);
`else
        check("nopinch_state", 32'(STATE), 2);
        check("nopinch_evt", 32'(PINCH_EVT), 0);
        UP_REQ = 1'b0;
        step(7); check("nopinch_idle", 32'(STATE), 0);
`endif

        // Limit wins over a simultaneous pinch; held UP at the top limit stays idle.
        step(2);
        UP_REQ = 1'b1;
        step(63);
        PINCH = 1'b1; TOP_LIM = 1'b1; step(1); PINCH = 1'b0;
        step(2);
        check("lim_pinch_state", 32'(STATE), 3);
        check("lim_pinch_evt", 32'(PINCH_EVT), 0);
        step(4); check("lim_idle", 32'(STATE), 0);
        step(10); check("lim_held_idle", 32'(STATE), 0);
        UP_REQ = 1'b0; step(2); UP_REQ = 1'b1;
        step(5); check("lim_reassert_idle", 32'(STATE), 0);
        UP_REQ = 1'b0; TOP_LIM = 1'b0;

        // Both requests, and DOWN at the bottom limit, stay idle.
        step(2);
        UP_REQ = 1'b1; DOWN_REQ = 1'b1;
        step(6); check("both_req_idle", 32'(STATE), 0);
        UP_REQ = 1'b0; BOT_LIM = 1'b1;
        step(6); check("down_at_bot_idle", 32'(STATE), 0);

        // Opening ramp, then bottom limit stops it.
        BOT_LIM = 1'b0;
        step(3);
        check("open_state", 32'(STATE), 1);
        check("open_dir", 32'(DIR), 0);
        check("open_duty", 32'(DUTY), 25);
        step(12);
        BOT_LIM = 1'b1;
        step(3); check("open_lim_stop", 32'(STATE), 3);
        check("open_lim_duty", 32'(DUTY), 0);
        DOWN_REQ = 1'b0; BOT_LIM = 1'b0;
        step(6);

        // Opposite request while closing stops; DIR is retained in STOP.
        UP_REQ = 1'b1;
        step(43);
        DOWN_REQ = 1'b1;
        step(3);
        check("opp_req_stop", 32'(STATE), 3);
        check("opp_req_dir", 32'(DIR), 1);
        UP_REQ = 1'b0; DOWN_REQ = 1'b0;
        step(6);

        // Asynchronous reset mid-motion.
        UP_REQ = 1'b1;
        step(3);
`ifdef ANTI_PINCH_EN
        step(80);
        PINCH = 1'b1; step(1); PINCH = 1'b0;
        step(10);
        check("pre_rst_reverse", 32'(STATE), 5);
`else
        step(40);
        check("pre_rst_run", 32'(STATE), 2);
        check("pre_rst_dir", 32'(DIR), 1);
`endif
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_duty", 32'(DUTY), 0);
        check("async_rst_dir", 32'(DIR), 0);
        check("async_rst_state", 32'(STATE), 0);
        check("async_rst_busy", 32'(BUSY), 0);
        UP_REQ = 1'b0;
        @(negedge SYSCLK);
        RST_N = 1'b1;
        step(5);
        check("post_rst_idle", 32'(STATE), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
